// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter with a single transaction in
// flight. Each transaction runs IDLE -> ACCESS -> RESP (3 cycles). The
// accepted request is lane-aligned onto a word-wide memory, and load data is
// lane-selected and sign/zero-extended before it is returned to the requester.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   pN*  (N = 0, 1)     request: Valid/We/Addr/Wdata/Size/Unsigned,
//                       Ready (combinational accept),
//                       response: RespValid/Rdata/Err (registered)
//   mem*                memWE/memA/memWD/memStrobe (registered),
//                       memRD (combinational read data from memory)
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority over port 1.
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0Valid,
  output logic        p0Ready,
  input  logic        p0We,
  input  logic [31:0] p0Addr,
  input  logic [31:0] p0Wdata,
  input  logic [1:0]  p0Size,
  input  logic        p0Unsigned,
  output logic        p0RespValid,
  output logic [31:0] p0Rdata,
  output logic        p0Err,
  input  logic        p1Valid,
  output logic        p1Ready,
  input  logic        p1We,
  input  logic [31:0] p1Addr,
  input  logic [31:0] p1Wdata,
  input  logic [1:0]  p1Size,
  input  logic        p1Unsigned,
  output logic        p1RespValid,
  output logic [31:0] p1Rdata,
  output logic        p1Err,
  output logic        memWE,
  output logic [31:0] memA,
  output logic [31:0] memWD,
  output logic [3:0]  memStrobe,
  input  logic [31:0] memRD
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic req_any;
  logic grant_id;
  logic accept;

`ifdef DMEM_ARB_RR_EN
  // ptr names the port that wins the next simultaneous request
  logic ptr;

  always_comb begin
    req_any = p0Valid | p1Valid;
    if (p0Valid && p1Valid) grant_id = ptr;
    else                    grant_id = p1Valid;
  end

  always_ff @(posedge clk) begin
    if (reset)       ptr <= 1'b0;
    else if (accept) ptr <= ~grant_id;
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not requesting
  always_comb begin
    req_any  = p0Valid | p1Valid;
    grant_id = ~p0Valid & p1Valid;
  end
`endif

  // Request fields of the port being granted, plus lane strobe/data
  logic          sel_we;
  logic          sel_uns;
  logic [DW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    sel_size;
  logic          sel_err;
  logic [SW-1:0] sel_strb;
  logic [DW-1:0] sel_wd;

  always_comb begin
    sel_we    = grant_id ? p1We       : p0We;
    sel_uns   = grant_id ? p1Unsigned : p0Unsigned;
    sel_addr  = grant_id ? p1Addr     : p0Addr;
    sel_wdata = grant_id ? p1Wdata    : p0Wdata;
    sel_size  = grant_id ? p1Size     : p0Size;
    sel_err   = (sel_size == SZ_RSVD)
              | ((sel_size == SZ_HALF) & sel_addr[0])
              | ((sel_size == SZ_WORD) & (sel_addr[1:0] != 2'b00));
    sel_strb  = '0;
    sel_wd    = sel_wdata;
    case (sel_size)
      SZ_BYTE: begin
        sel_strb = 4'b0001 << sel_addr[1:0];
        sel_wd   = {4{sel_wdata[7:0]}};
      end
      SZ_HALF: begin
        sel_strb = 4'b0011 << sel_addr[1:0];
        sel_wd   = {2{sel_wdata[15:0]}};
      end
      SZ_WORD: sel_strb = 4'b1111;
      default: sel_strb = '0;
    endcase
    // A faulting access never touches memory
    if (sel_err) sel_strb = '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and combinational accept
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    p0Ready    = 1'b0;
    p1Ready    = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          accept     = 1'b1;
          p0Ready    = ~grant_id;
          p1Ready    = grant_id;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured transaction attributes needed after acceptance
  logic       cap_id;
  logic       cap_we;
  logic [1:0] cap_lane;
  logic [1:0] cap_size;
  logic       cap_uns;
  logic       cap_err;

  // Load lane select and extension; stores and faults return zero
  logic [DW-1:0] lane_data;
  logic [DW-1:0] load_val;

  always_comb begin
    lane_data = memRD >> {cap_lane, 3'b000};
    case (cap_size)
      SZ_BYTE: load_val = {{24{lane_data[7] & ~cap_uns}}, lane_data[7:0]};
      SZ_HALF: load_val = {{16{lane_data[15] & ~cap_uns}}, lane_data[15:0]};
      default: load_val = lane_data;
    endcase
    if (cap_we | cap_err) load_val = '0;
  end

  // Registered memory-side and response-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      memWE       <= 1'b0;
      memA        <= '0;
      memWD       <= '0;
      memStrobe   <= '0;
      p0RespValid <= 1'b0;
      p0Rdata     <= '0;
      p0Err       <= 1'b0;
      p1RespValid <= 1'b0;
      p1Rdata     <= '0;
      p1Err       <= 1'b0;
      cap_id      <= 1'b0;
      cap_we      <= 1'b0;
      cap_lane    <= '0;
      cap_size    <= '0;
      cap_uns     <= 1'b0;
      cap_err     <= 1'b0;
    end else begin
      memWE       <= 1'b0;
      p0RespValid <= 1'b0;
      p0Rdata     <= '0;
      p0Err       <= 1'b0;
      p1RespValid <= 1'b0;
      p1Rdata     <= '0;
      p1Err       <= 1'b0;
      if (accept) begin
        memWE     <= sel_we & ~sel_err;
        memA      <= {sel_addr[31:2], 2'b00};
        memWD     <= sel_wd;
        memStrobe <= sel_strb;
        cap_id    <= grant_id;
        cap_we    <= sel_we;
        cap_lane  <= sel_addr[1:0];
        cap_size  <= sel_size;
        cap_uns   <= sel_uns;
        cap_err   <= sel_err;
      end
      // Leaving ACCESS: load data is sampled here and shown during RESP
      if (state == ACCESS) begin
        if (cap_id) begin
          p1RespValid <= 1'b1;
          p1Rdata     <= load_val;
          p1Err       <= cap_err;
        end else begin
          p0RespValid <= 1'b1;
          p0Rdata     <= load_val;
          p0Err       <= cap_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. A byte-addressed
// reference memory and transaction-level timing model predict every output
// each cycle; directed sequences pin the model with literal values.
`timescale 1ns/1ps
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        p0Valid, p0Ready, p0We, p0Unsigned, p0RespValid, p0Err;
  logic [31:0] p0Addr, p0Wdata, p0Rdata;
  logic [1:0]  p0Size;
  logic        p1Valid, p1Ready, p1We, p1Unsigned, p1RespValid, p1Err;
  logic [31:0] p1Addr, p1Wdata, p1Rdata;
  logic [1:0]  p1Size;
  logic        memWE;
  logic [31:0] memA, memWD, memRD;
  logic [3:0]  memStrobe;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;
  logic mem_clr;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0Valid(p0Valid), .p0Ready(p0Ready), .p0We(p0We), .p0Addr(p0Addr),
    .p0Wdata(p0Wdata), .p0Size(p0Size), .p0Unsigned(p0Unsigned),
    .p0RespValid(p0RespValid), .p0Rdata(p0Rdata), .p0Err(p0Err),
    .p1Valid(p1Valid), .p1Ready(p1Ready), .p1We(p1We), .p1Addr(p1Addr),
    .p1Wdata(p1Wdata), .p1Size(p1Size), .p1Unsigned(p1Unsigned),
    .p1RespValid(p1RespValid), .p1Rdata(p1Rdata), .p1Err(p1Err),
    .memWE(memWE), .memA(memA), .memWD(memWD), .memStrobe(memStrobe),
    .memRD(memRD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0F0F;
  endfunction

  // Word-wide memory attached to the DUT: synchronous byte-strobed write
  logic [31:0] tbmem [16];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) tbmem[i] <= seed_word(i);
    end else if (memWE) begin
      for (int b = 0; b < 4; b++)
        if (memStrobe[b]) tbmem[memA[5:2]][8*b +: 8] <= memWD[8*b +: 8];
    end
  end
  assign memRD = tbmem[memA[5:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and per-cycle compare
  logic [7:0] ref_mem [64];

  initial begin : cmp
    int n, acc, pref, win, e_port, nb, base;
    bit txn, rst_prev, free, resp_now;
    logic we, un;
    logic [1:0]  sz;
    logic [31:0] a, wd, v, sw, e_a, e_wd, e_rd;
    logic [3:0]  e_strb;
    logic e_we, e_err;
    n = 0; txn = 0; acc = -100; pref = 0; rst_prev = 0; e_port = 0;
    e_a = '0; e_wd = '0; e_rd = '0; e_strb = '0; e_we = 0; e_err = 0;
    for (int w = 0; w < 16; w++) begin
      sw = seed_word(w);
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = sw[8*b +: 8];
    end
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (txn && n == acc + 1) begin
        chk("mem_we", 32'(memWE), 32'(e_we));
        if (!e_err) begin
          chk("mem_a", memA, e_a);
          chk("mem_strb", 32'(memStrobe), 32'(e_strb));
          chk("mem_wd", memWD, e_wd);
        end
      end else begin
        chk("mem_we_idle", 32'(memWE), 0);
      end
      resp_now = txn && (n == acc + 2);
      chk("p0_rv", 32'(p0RespValid), 32'(resp_now && e_port == 0));
      chk("p1_rv", 32'(p1RespValid), 32'(resp_now && e_port == 1));
      if (resp_now && e_port == 0) begin
        chk("p0_rd", p0Rdata, e_rd);
        chk("p0_err", 32'(p0Err), 32'(e_err));
      end
      if (resp_now && e_port == 1) begin
        chk("p1_rd", p1Rdata, e_rd);
        chk("p1_err", 32'(p1Err), 32'(e_err));
      end
      if (rst_prev) begin
        chk("rst_mem_a", memA, 0);
        chk("rst_mem_wd", memWD, 0);
        chk("rst_mem_strb", 32'(memStrobe), 0);
        chk("rst_p0_rd", p0Rdata, 0);
        chk("rst_p1_rd", p1Rdata, 0);
        chk("rst_err", 32'({p1Err, p0Err}), 0);
      end
      free = !txn || (n >= acc + 3);
      win = -1;
      if (free) begin
        if (p0Valid && p1Valid) win = RR_EN ? pref : 0;
        else if (p0Valid)       win = 0;
        else if (p1Valid)       win = 1;
      end
      chk("p0_ready", 32'(p0Ready), 32'(win == 0));
      chk("p1_ready", 32'(p1Ready), 32'(win == 1));
      if (reset) begin
        txn = 0; pref = 0; rst_prev = 1;
      end else begin
        rst_prev = 0;
        if (win >= 0) begin
          txn = 1; acc = n; e_port = win;
          if (win == 0) begin we = p0We; a = p0Addr; wd = p0Wdata; sz = p0Size; un = p0Unsigned; end
          else          begin we = p1We; a = p1Addr; wd = p1Wdata; sz = p1Size; un = p1Unsigned; end
          e_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
          e_we  = we && !e_err;
          e_a   = {a[31:2], 2'b00};
          nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
          base  = int'(a[5:0]);
          e_strb = '0;
          for (int i = 0; i < nb; i++) e_strb[(int'(a[1:0]) + i) % 4] = 1'b1;
          for (int b = 0; b < 4; b++) e_wd[8*b +: 8] = wd[8*(b % nb) +: 8];
          e_rd = '0;
          if (!e_err && !we) begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[base + i];
            if (!un && nb < 4 && v[8*nb - 1])
              for (int i = nb * 8; i < 32; i++) v[i] = 1'b1;
            e_rd = v;
          end
          if (!e_err && we)
            for (int i = 0; i < nb; i++) ref_mem[base + i] = wd[8*i +: 8];
          if (RR_EN) pref = 1 - win;
        end
      end
    end
  end

  // Stimulus helpers (called at posedge + 1)
  task automatic set_req(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic un);
    if (p == 0) begin p0Valid = 1; p0We = we; p0Addr = a; p0Wdata = wd; p0Size = sz; p0Unsigned = un; end
    else        begin p1Valid = 1; p1We = we; p1Addr = a; p1Wdata = wd; p1Size = sz; p1Unsigned = un; end
  endtask

  task automatic rand_req(input int p);
    logic [1:0]  sz;
    logic [31:0] a;
    sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    a  = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
    end
    set_req(p, 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_accept(input int p, output int lat);
    bit got;
    got = 0; lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((p == 0 && p0Ready) || (p == 1 && p1Ready)) begin got = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    chk("accept_timeout", 32'(got), 1);
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic un,
                       output logic o_we, output logic [3:0] o_strb, output logic [31:0] o_wd,
                       output logic o_rv, output logic [31:0] o_rd, output logic o_err, output int lat);
    set_req(p, we, a, wd, sz, un);
    wait_accept(p, lat);
    @(posedge clk); #1;
    if (p == 0) p0Valid = 0; else p1Valid = 0;
    @(negedge clk);
    o_we = memWE; o_strb = memStrobe; o_wd = memWD;
    @(negedge clk);
    o_rv  = (p == 0) ? p0RespValid : p1RespValid;
    o_rd  = (p == 0) ? p0Rdata     : p1Rdata;
    o_err = (p == 0) ? p0Err       : p1Err;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    p0Valid = 0; p1Valid = 0; reset = 1;
    repeat (cycles) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin : main
    logic r_we, r_rv, r_err;
    logic [3:0]  r_strb;
    logic [31:0] r_wd, r_rd;
    int lat, ng, consec;
    bit prev_rv, t0, t1;
    int g [4];
    int gc [4];
    reset = 1; mem_clr = 1;
    p0Valid = 0; p0We = 0; p0Addr = '0; p0Wdata = '0; p0Size = '0; p0Unsigned = 0;
    p1Valid = 0; p1We = 0; p1Addr = '0; p1Wdata = '0; p1Size = '0; p1Unsigned = 0;
    repeat (4) @(posedge clk);
    #1 reset = 0; mem_clr = 0;

    // Word store then load on port 0
    issue(0, 1, 32'h4, 32'h12345678, 2'b10, 0, r_we, r_strb, r_wd, r_rv, r_rd, r_err, lat);
    chk("d_stw_we", 32'(r_we), 1);
    chk("d_stw_strb", 32'(r_strb), 32'hF);
    chk("d_stw_wd", r_wd, 32'h12345678);
    chk("d_stw_rd", r_rd, 0);
    issue(0, 0, 32'h4, 32'h0, 2'b10, 0, r_we, r_strb, r_wd, r_rv, r_rd, r_err, lat);
    chk("d_ldw_rv", 32'(r_rv), 1);
    chk("d_ldw_rd", r_rd, 32'h12345678);

    // Byte store, signed and unsigned byte loads on port 1
    issue(1, 1, 32'h6, 32'h000000AB, 2'b00, 0, r_we, r_strb, r_wd, r_rv, r_rd, r_err, lat);
    chk("d_stb_strb", 32'(r_strb), 32'h4);
    chk("d_stb_wd", r_wd, 32'hABABABAB);
    issue(1, 0, 32'h6, 32'h0, 2'b00, 0, r_we, r_strb, r_wd, r_rv, r_rd, r_err, lat);
    chk("d_ldb_s", r_rd, 32'hFFFFFFAB);
    issue(1, 0, 32'h6, 32'h0, 2'b00, 1, r_we, r_strb, r_wd, r_rv, r_rd, r_err, lat);
    chk("d_ldb_u", r_rd, 32'h000000AB);

    // Misaligned and reserved-size errors
    issue(0, 0, 32'h3, 32'h0, 2'b01, 0, r_we, r_strb, r_wd, r_rv, r_rd, r_err, lat);
    chk("d_ldh_err", 32'(r_err), 1);
    chk("d_ldh_rd", r_rd, 0);
    chk("d_ldh_we", 32'(r_we), 0);
    issue(0, 1, 32'h3, 32'hFFFF, 2'b01, 0, r_we, r_strb, r_wd, r_rv, r_rd, r_err, lat);
    chk("d_sth_we", 32'(r_we), 0);
    chk("d_sth_err", 32'(r_err), 1);
    issue(0, 0, 32'h8, 32'h0, 2'b11, 0, r_we, r_strb, r_wd, r_rv, r_rd, r_err, lat);
    chk("d_rsvd_err", 32'(r_err), 1);

    // Reset during the ACCESS cycle of a port-1 store
    set_req(1, 1, 32'h8, 32'hCAFEF00D, 2'b10, 0);
    wait_accept(1, lat);
    @(posedge clk); #1;
    p1Valid = 0; reset = 1;
    @(negedge clk);
    chk("d_rst_acc_we", 32'(memWE), 1);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("d_rst_no_rv", 32'(p1RespValid), 0);
    chk("d_rst_zero", 32'({memWE, memStrobe}) | memA | memWD | p1Rdata, 0);
    @(posedge clk); #1;
    issue(1, 0, 32'h8, 32'h0, 2'b10, 0, r_we, r_strb, r_wd, r_rv, r_rd, r_err, lat);
    chk("d_rst_idle_lat", 32'(lat), 0);
    chk("d_rst_wr_done", r_rd, 32'hCAFEF00D);

    // Both ports held valid for four grants
    do_reset(2);
    set_req(0, 0, 32'h0, 32'h0, 2'b10, 0);
    set_req(1, 0, 32'h4, 32'h0, 2'b10, 0);
    ng = 0; consec = 0; prev_rv = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if ((p0RespValid || p1RespValid) && prev_rv) consec++;
      prev_rv = p0RespValid || p1RespValid;
      if (p0Ready)      begin g[ng] = 0; gc[ng] = k; ng++; end
      else if (p1Ready) begin g[ng] = 1; gc[ng] = k; ng++; end
      @(posedge clk); #1;
    end
    p0Valid = 0; p1Valid = 0;
    chk("d_arb_count", 32'(ng), 4);
    for (int i = 0; i < ng; i++) chk("d_arb_grant", 32'(g[i]), RR_EN ? 32'(i % 2) : 0);
    for (int i = 1; i < ng; i++) chk("d_arb_spacing", 32'(gc[i] - gc[i-1]), 3);
    chk("d_resp_gap", 32'(consec), 0);

    // Randomized traffic on both ports
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      t0 = p0Ready; t1 = p1Ready;
      @(posedge clk); #1;
      if (t0 || !p0Valid) begin
        if ($urandom_range(0, 2) != 0) rand_req(0); else p0Valid = 0;
      end
      if (t1 || !p1Valid) begin
        if ($urandom_range(0, 2) != 0) rand_req(1); else p1Valid = 0;
      end
    end
    p0Valid = 0; p1Valid = 0;
    repeat (6) @(posedge clk);
    done = 1;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
